// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and load/store sequencer for a single-cycle word-wide memory.
// Loads are lane-selected and extended; sub-word stores run as read-modify-write.
module dmem_arbiter #(
    parameter int unsigned DEPTH = 40,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [31:0]   p0_wdata,
    input  logic [2:0]    p0_fun3,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [31:0]   p0_rdata,
    output logic          p0_err,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [31:0]   p1_wdata,
    input  logic [2:0]    p1_fun3,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [31:0]   p1_rdata,
    output logic          p1_err,

    output logic [31:0]   mem_address,
    output logic [31:0]   mem_write_data,
    output logic [2:0]    mem_fun3,
    output logic          mem_rd_en,
    output logic          mem_wd_en,
    input  logic [31:0]   mem_rdata
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RMW_WR = 2'd2;

    logic [1:0]    r_state;
    logic          r_ptr;
    logic          r_port;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [2:0]    r_fun3;
    logic [31:0]   r_old;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic [31:0]   r_rdata0;
    logic [31:0]   r_rdata1;
    logic          r_err0;
    logic          r_err1;

    logic          w_idle;
    logic          w_gnt0;
    logic          w_gnt1;
    logic [AW-1:0] w_index;
    logic          w_fun3_ok;
    logic          w_misalign;
    logic          w_err;
    logic          w_sub_store;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;
    logic [31:0]   w_merged;
    logic          w_done;
    logic [31:0]   w_done_data;

    // Ties go to the pointer's port; a lone requester wins regardless.
    assign w_idle = (r_state == S_IDLE) && !rst;
    assign w_gnt0 = w_idle && p0_req && (!p1_req || !r_ptr);
    assign w_gnt1 = w_idle && p1_req && (!p0_req || r_ptr);
    assign p0_gnt = w_gnt0;
    assign p1_gnt = w_gnt1;

    assign w_index = r_addr >> 2;

    always_comb begin
        case (r_fun3)
            3'b000, 3'b001, 3'b010: w_fun3_ok = 1'b1;
            3'b100, 3'b101:         w_fun3_ok = !r_we;
            default:                w_fun3_ok = 1'b0;
        endcase
        w_misalign = ((r_fun3[1:0] == 2'b01) && r_addr[0]) ||
                     ((r_fun3 == 3'b010) && (r_addr[1:0] != 2'b00));
        w_err      = !w_fun3_ok || w_misalign || (w_index >= AW'(DEPTH));
    end

    assign w_sub_store = r_we && (r_fun3[2:1] == 2'b00);

    assign w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = mem_rdata[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        case (r_fun3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    always_comb begin
        w_merged = r_old;
        if (r_fun3[0]) begin
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
        end else begin
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end
    end

    assign mem_fun3 = 3'b010;

    // Error transactions still walk through ACCESS, but never touch the memory.
    always_comb begin
        mem_address    = 32'd0;
        mem_write_data = 32'd0;
        mem_rd_en      = 1'b0;
        mem_wd_en      = 1'b0;
        if (!rst && (r_state != S_IDLE)) begin
            mem_address = 32'(w_index);
            if ((r_state == S_ACCESS) && !w_err) begin
                if (!r_we || w_sub_store) begin
                    mem_rd_en = 1'b1;
                end else begin
                    mem_wd_en      = 1'b1;
                    mem_write_data = r_wdata;
                end
            end else if (r_state == S_RMW_WR) begin
                mem_wd_en      = 1'b1;
                mem_write_data = w_merged;
            end
        end
    end

    assign w_done = ((r_state == S_ACCESS) && (w_err || !w_sub_store)) ||
                    (r_state == S_RMW_WR);
    assign w_done_data = ((r_state == S_ACCESS) && !w_err && !r_we) ? w_load : 32'd0;

    always_ff @(posedge clk) begin
        r_rvalid0 <= 1'b0;
        r_rvalid1 <= 1'b0;
        if (rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= 1'b0;
            r_port   <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_fun3   <= 3'd0;
            r_old    <= 32'd0;
            r_rdata0 <= 32'd0;
            r_rdata1 <= 32'd0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_state <= S_ACCESS;
                        r_port  <= w_gnt1;
                        r_ptr   <= !w_gnt1;
                        r_we    <= w_gnt1 ? p1_we    : p0_we;
                        r_addr  <= w_gnt1 ? p1_addr  : p0_addr;
                        r_wdata <= w_gnt1 ? p1_wdata : p0_wdata;
                        r_fun3  <= w_gnt1 ? p1_fun3  : p0_fun3;
                    end
                end
                S_ACCESS: begin
                    r_old   <= mem_rdata;
                    r_state <= (!w_err && w_sub_store) ? S_RMW_WR : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_done) begin
                if (r_port) begin
                    r_rvalid1 <= 1'b1;
                    r_rdata1  <= w_done_data;
                    r_err1    <= (r_state == S_ACCESS) && w_err;
                end else begin
                    r_rvalid0 <= 1'b1;
                    r_rdata0  <= w_done_data;
                    r_err0    <= (r_state == S_ACCESS) && w_err;
                end
            end
        end
    end

    assign p0_rvalid = r_rvalid0;
    assign p0_rdata  = r_rdata0;
    assign p0_err    = r_err0;
    assign p1_rvalid = r_rvalid1;
    assign p1_rdata  = r_rdata1;
    assign p1_err    = r_err1;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and load/store sequencer in front of the single-cycle word-wide data memory. It shares the memory between the core load/store path (port 0) and a DMA/debug master (port 1) using round-robin arbitration. It converts byte addresses to word indices and performs byte/halfword extraction and sign/zero extension for loads. Sub-word stores run as read-modify-write sequences, because the memory only writes full words.

## Interface

Parameters:
- DEPTH, 40: number of 32-bit words in the attached memory.
- AW, 32: requester byte-address width.

Ports. Both ports are identical; pN is p0 or p1. Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pN_req  in  1  request; held with its fields stable until pN_gnt.
- pN_we  in  1  1 = store, 0 = load.
- pN_addr  in  AW  byte address.
- pN_wdata  in  32  store data, right-aligned.
- pN_fun3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- pN_gnt  out  1  one-cycle accept pulse.
- pN_rvalid  out  1  one-cycle completion pulse.
- pN_rdata  out  32  extended load data; valid with rvalid.
- pN_err  out  1  error flag; valid with rvalid.
- mem_address  out  32  word index (pN_addr >> 2).
- mem_write_data  out  32  full word to write.
- mem_fun3  out  3  always 3'b010.
- mem_rd_en  out  1  memory read enable.
- mem_wd_en  out  1  memory write enable; memory writes at the clk edge.
- mem_rdata  in  32  combinational read word.

## Operation

- States:
  - IDLE: arbitrate. Assert gnt combinationally to the winner and latch its we/addr/wdata/fun3.
  - ACCESS: one memory cycle.
  - RMW_WR: sub-word store write.
- Transitions:
  - IDLE to ACCESS on any grant.
  - ACCESS to RMW_WR for legal SB/SH.
  - ACCESS to IDLE otherwise.
  - RMW_WR to IDLE.
- Arbitration:
  - Round-robin priority pointer, reset to port 0.
  - After a grant to port p, the pointer moves to the other port.
  - With a single requester, that requester wins regardless of the pointer.
  - Grants occur only in IDLE.
- Error checks, done on the latched request. Any of the following completes with err=1, rdata=0, and mem_rd_en=mem_wd_en=0 throughout:
  - Load with fun3 not in {000,001,010,100,101}.
  - Store with fun3 not in {000,001,010}.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Word index (addr>>2) >= DEPTH.
- Loads, in ACCESS:
  - Drive mem_rd_en=1 and mem_fun3=010.
  - Select the lane by addr[1:0]: byte = word[8*off+7:8*off]; half = word[16*addr[1]+15:16*addr[1]].
  - Sign-extend for 000/001; zero-extend for 100/101.
  - Register the result into the port's rdata.
- SW, in ACCESS: mem_wd_en=1, mem_write_data=wdata.
- SB/SH:
  - ACCESS: mem_rd_en=1; register the old word.
  - RMW_WR: mem_wd_en=1; write the old word with only the addressed lane replaced by wdata[7:0] or wdata[15:0].
- mem_address holds the latched word index in ACCESS and RMW_WR; it is 0 in IDLE.
- mem_rd_en and mem_wd_en are 0 outside ACCESS/RMW_WR and whenever rst=1.
- rvalid/rdata/err go only to the port that was granted.
- pN_rdata and pN_err hold their last values until the next completion.

## Timing

- Grant at cycle t (IDLE):
  - Load / SW / error: memory cycle at t+1; rvalid at t+2.
  - SB/SH: read at t+1, write edge at the end of t+2, rvalid at t+3.
- rvalid coincides with IDLE, so a new grant can issue in the same cycle as the previous rvalid. Throughput is one word access per 2 cycles, one sub-word store per 3 cycles.
- gnt depends combinationally on req and state only, never on mem_rdata.
- Reset values:
  - State IDLE, pointer = port 0.
  - All gnt/rvalid/err = 0, rdata = 0.
  - mem_* outputs = 0, except mem_fun3 = 010.
- Reset mid-transaction drops it. No rvalid is ever produced for it, no memory write occurs in the reset cycle, and a pending RMW write is abandoned.
- Simultaneous req on both ports in IDLE: only the pointer's port gets gnt. The loser keeps req asserted and is granted in the next IDLE cycle.

## Test plan

- Preload word 2 = 0x8081_F0A5. p0 LB addr 0x9 -> rvalid 2 cycles after gnt, rdata 0xFFFF_FFF0. LBU addr 0xB -> 0x0000_0080. LHU addr 0xA -> 0x0000_8081.
- Word 3 = 0x1122_3344. p1 SB addr 0xD wdata 0xAB -> mem read cycle then write cycle, rvalid at t+3. A subsequent LW of 0xC returns 0x1122_AB44.
- Both ports request LW every cycle from reset -> grants alternate p0, p1, p0, ... with one gnt every 2 cycles and no rvalid on the non-granted port.
- Errors: LW addr 0x6, SH addr 0x5, LW addr 160 (index 40), store fun3 100 -> each returns err=1, rdata=0, and mem_wd_en never asserts (memory contents unchanged).
- Assert rst during RMW_WR of an SH -> no mem_wd_en that cycle, no rvalid, target word unchanged. The next request is granted to p0 first.
- Back-to-back: p0 SW addr 0x0 data 0xDEAD_BEEF, then immediately LW addr 0x0 -> second gnt coincides with first rvalid, and the load returns 0xDEAD_BEEF.
